// File: rtl/run_stream_gen_if.sv
// Token and serial-stream signals of the run-length stream generator.
// The master side supplies tokens; the slave side is the generator.
interface run_stream_gen_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             bit_in;
    logic [LEN_W-1:0] len_in;
    logic             ready;
    logic             w;
    logic             w_valid;
    logic             run_done;
    logic [CNT_W-1:0] run_cnt;

    modport master (
        output start, bit_in, len_in,
        input  ready, w, w_valid, run_done, run_cnt
    );

    modport slave (
        input  start, bit_in, len_in,
        output ready, w, w_valid, run_done, run_cnt
    );
endinterface

// File: rtl/run_stream_gen.sv
// Run-length stimulus generator: turns (bit, length) tokens into a serial
// stream of equal bits, with a one-deep pending slot for gapless back-to-back runs.
module run_stream_gen #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    run_stream_gen_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_reg;
    logic             act_bit_reg;
    logic [LEN_W-1:0] act_rem_reg;
    logic             pend_bit_reg;
    logic [LEN_W-1:0] pend_len_reg;
    logic             pend_valid_reg;
    logic [CNT_W-1:0] run_cnt_reg;

    logic             accept;
    logic             last_bit;

    // Zero-length tokens are handshaken but never occupy a slot.
    assign accept   = bus.start && !pend_valid_reg && (bus.len_in != '0);
    assign last_bit = (state_reg == SEND) && (act_rem_reg == LEN_W'(1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg      <= IDLE;
            act_bit_reg    <= 1'b0;
            act_rem_reg    <= '0;
            pend_bit_reg   <= 1'b0;
            pend_len_reg   <= '0;
            pend_valid_reg <= 1'b0;
            run_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg   <= SEND;
                        act_bit_reg <= bus.bit_in;
                        act_rem_reg <= bus.len_in;
                    end
                end
                SEND: begin
                    if (act_rem_reg == LEN_W'(1)) begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                        // A full pending slot blocks acceptance, so it always wins here.
                        if (pend_valid_reg) begin
                            act_bit_reg    <= pend_bit_reg;
                            act_rem_reg    <= pend_len_reg;
                            pend_valid_reg <= 1'b0;
                        end else if (accept) begin
                            act_bit_reg <= bus.bit_in;
                            act_rem_reg <= bus.len_in;
                        end else begin
                            state_reg   <= IDLE;
                            act_rem_reg <= '0;
                        end
                    end else begin
                        act_rem_reg <= act_rem_reg - 1'b1;
                        if (accept) begin
                            pend_bit_reg   <= bus.bit_in;
                            pend_len_reg   <= bus.len_in;
                            pend_valid_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ready    = !pend_valid_reg;
    assign bus.w_valid  = (state_reg == SEND);
    assign bus.w        = (state_reg == SEND) ? act_bit_reg : 1'b0;
    assign bus.run_done = last_bit;
    assign bus.run_cnt  = run_cnt_reg;

endmodule

// File: tb/tb_run_stream_gen.sv
// Scoreboard bench for run_stream_gen: accepted tokens expand into expected
// per-cycle bits in a queue; a negedge monitor pops and compares the stream.
module tb_run_stream_gen;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    typedef struct {
        logic b;
        logic last;
    } exp_bit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_bit_t q[$];
    int       ndone = 0;    // runs still represented in q (one last-bit each)
    int       exp_cnt = 0;

    run_stream_gen_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) ifc ();

    run_stream_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .Clock (clk),
        .Resetn(rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: the stream is the concatenation of accepted runs, emitted
    // without gaps; ready is low exactly when a second run is waiting.
    always @(negedge clk) begin
        exp_bit_t e;
        chk("ready", int'(ifc.ready), (ndone <= 1) ? 1 : 0);
        chk("run_cnt", int'(ifc.run_cnt), exp_cnt % CNT_MOD);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("w_valid", int'(ifc.w_valid), 1);
            chk("w", int'(ifc.w), int'(e.b));
            chk("run_done", int'(ifc.run_done), int'(e.last));
            if (e.last) begin
                ndone--;
                exp_cnt++;
            end
        end else begin
            chk("idle_w_valid", int'(ifc.w_valid), 0);
            chk("idle_w", int'(ifc.w), 0);
            chk("idle_run_done", int'(ifc.run_done), 0);
        end
    end

    // Presents a token until accepted; returns 1 time unit after the accepting edge
    // with start still asserted so back-to-back calls keep it held.
    task automatic send(input logic b, input int l);
        logic rdy;
        int   guard;
        guard = 0;
        ifc.start  = 1'b1;
        ifc.bit_in = b;
        ifc.len_in = LEN_W'(l);
        do begin
            @(negedge clk);
            rdy = ifc.ready;
            @(posedge clk);
            guard++;
        end while (!rdy && guard < 100);
        #1;
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
        end else begin
            for (int i = 0; i < l; i++) begin
                q.push_back('{b: b, last: (i == l - 1)});
            end
            if (l > 0) ndone++;
        end
    endtask

    task automatic idle(input int n);
        ifc.start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ifc.start = 1'b0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        ndone = 0;
        exp_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        ifc.start  = 1'b0;
        ifc.bit_in = 1'b0;
        ifc.len_in = '0;
        #2;
        do_reset();
        idle(2);

        // single run, then held-start chain through the pending slot
        send(1'b0, 4);
        drain();
        send(1'b0, 3);
        send(1'b1, 3);
        send(1'b0, 2);
        drain();
        chk("chain_run_cnt", int'(ifc.run_cnt), 4);

        // zero-length token is swallowed
        send(1'b1, 0);
        idle(4);
        chk("zero_len_run_cnt", int'(ifc.run_cnt), 4);

        // maximum length, then a length-1 run merging onto it
        send(1'b1, 15);
        send(1'b1, 1);
        drain();
        chk("max_len_run_cnt", int'(ifc.run_cnt), 6);

        // asynchronous reset in the middle of a run with pending occupied
        send(1'b0, 5);
        send(1'b1, 4);
        ifc.start = 1'b0;
        rst_n = 1'b0;
        q.delete();
        ndone = 0;
        exp_cnt = 0;
        #1;
        chk("async_rst_w_valid", int'(ifc.w_valid), 0);
        chk("async_rst_ready", int'(ifc.ready), 1);
        chk("async_rst_run_cnt", int'(ifc.run_cnt), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        chk("post_rst_w_valid", int'(ifc.w_valid), 0);

        // randomized tokens with random gaps
        for (int i = 0; i < 60; i++) begin
            logic rb;
            int   rl;
            rb = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            send(rb, rl);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
        end
        drain();

        // counter wrap after 256 single-bit runs
        do_reset();
        idle(1);
        for (int i = 0; i < 256; i++) send(1'($urandom_range(0, 1)), 1);
        drain();
        chk("wrap_run_cnt", int'(ifc.run_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
